// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory pins around dmem_arbiter.
// slave = arbiter side; master = requesters plus the memory itself.
interface dmem_arbiter_if;
  logic        p0_req, p0_we, p0_lock;
  logic [31:0] p0_addr, p0_wdata;
  logic        p0_gnt, p0_rvalid, p0_err;
  logic [31:0] p0_rdata;

  logic        p1_req, p1_we, p1_lock;
  logic [31:0] p1_addr, p1_wdata;
  logic        p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p1_rdata;

  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        lock_timeout;

  modport slave (
    input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_gnt, p0_rvalid, p0_err, p0_rdata,
    output p1_gnt, p1_rvalid, p1_err, p1_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    output lock_timeout
  );

  modport master (
    output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_gnt, p0_rvalid, p0_err, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_err, p1_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    input  lock_timeout
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded exclusive locks sharing one single-ported data memory
// between the MEM stage (port 0) and the debug/DMA loader (port 1).
module dmem_arbiter #(
  parameter int unsigned DEPTH    = 4096,
  parameter int unsigned LOCK_MAX = 4
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [1:0]    err_q, err_d;
  logic [31:0]   rdata0_q, rdata0_d;
  logic [31:0]   rdata1_q, rdata1_d;
  logic          lock_timeout_q, lock_timeout_d;

  logic [1:0]    req, lock, gnt;
  logic          sel, sel_we, sel_lock, sel_err, good, own_lock;
  logic [31:0]   sel_addr, sel_wdata;

  assign req  = {bus.p1_req, bus.p0_req};
  assign lock = {bus.p1_lock, bus.p0_lock};

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      case (state_q)
        OWN0:    gnt = {1'b0, req[0]};
        OWN1:    gnt = {req[1], 1'b0};
        default: gnt = (&req) ? (last_q ? 2'b01 : 2'b10) : req;
      endcase
    end
  end

  assign sel       = gnt[1];
  assign sel_we    = sel ? bus.p1_we    : bus.p0_we;
  assign sel_lock  = sel ? lock[1]      : lock[0];
  assign sel_addr  = sel ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = sel ? bus.p1_wdata : bus.p0_wdata;
  assign sel_err   = (sel_addr[1:0] != 2'b00) || ({2'b00, sel_addr[31:2]} >= 32'(DEPTH));
  assign good      = (|gnt) && !sel_err;
  assign own_lock  = (state_q == OWN1) ? lock[1] : lock[0];

  assign bus.p0_gnt    = gnt[0];
  assign bus.p1_gnt    = gnt[1];
  assign bus.mem_read  = good && !sel_we;
  assign bus.mem_write = good && sel_we;
  assign bus.mem_addr  = good ? sel_addr  : '0;
  assign bus.mem_wdata = good ? sel_wdata : '0;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_d         = last_q;
    lock_timeout_d = 1'b0;
    if (|gnt) last_d = sel;
    case (state_q)
      IDLE: begin
        if ((|gnt) && sel_lock) begin
          state_d = sel ? OWN1 : OWN0;
          cnt_d   = CW'(1);
        end
      end
      OWN0, OWN1: begin
        // The count runs whether or not the owner actually requests.
        if (!own_lock) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_MAX - 1)) begin
          state_d        = IDLE;
          cnt_d          = '0;
          lock_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rvalid_d = gnt;
    err_d    = gnt & {2{sel_err}};
    rdata0_d = (gnt[0] && good && !sel_we) ? bus.mem_rdata : '0;
    rdata1_d = (gnt[1] && good && !sel_we) ? bus.mem_rdata : '0;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      last_q         <= 1'b1;
      rvalid_q       <= 2'b00;
      err_q          <= 2'b00;
      rdata0_q       <= '0;
      rdata1_q       <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_q         <= last_d;
      rvalid_q       <= rvalid_d;
      err_q          <= err_d;
      rdata0_q       <= rdata0_d;
      rdata1_q       <= rdata1_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  assign bus.p0_rvalid    = rvalid_q[0];
  assign bus.p1_rvalid    = rvalid_q[1];
  assign bus.p0_err       = err_q[0];
  assign bus.p1_err       = err_q[1];
  assign bus.p0_rdata     = rdata0_q;
  assign bus.p1_rdata     = rdata1_q;
  assign bus.lock_timeout = lock_timeout_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle grant/strobe checks plus a response
// scoreboard that pairs each expected grant with the registered response a cycle later.
module tb_dmem_arbiter;
  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.DEPTH(4096), .LOCK_MAX(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Memory model: synchronous write, combinational read.
  logic [31:0] mem_model [0:4095];
  always @(posedge clk) if (bus.mem_write) mem_model[bus.mem_addr[13:2]] <= bus.mem_wdata;
  assign bus.mem_rdata = mem_model[bus.mem_addr[13:2]];

  int    n_tests = 0;
  int    n_fail  = 0;
  resp_t q0[$];
  resp_t q1[$];
  logic [1:0] rv_exp = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_p0(input logic r, w, l, input logic [31:0] a, d);
    bus.p0_req = r; bus.p0_we = w; bus.p0_lock = l; bus.p0_addr = a; bus.p0_wdata = d;
  endtask

  task automatic set_p1(input logic r, w, l, input logic [31:0] a, d);
    bus.p1_req = r; bus.p1_we = w; bus.p1_lock = l; bus.p1_addr = a; bus.p1_wdata = d;
  endtask

  task automatic check_resp(input string tag, input logic rv, input logic er,
                            input logic [31:0] rd, inout resp_t q[$]);
    resp_t e;
    if (rv) begin
      chk({tag, "_sb_nonempty"}, 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk({tag, "_err"}, 32'(er), 32'(e.err));
        chk({tag, "_rdata"}, rd, e.rdata);
      end
    end
  endtask

  // One clock cycle: inputs are already applied; maddr of all-X skips the address check.
  task automatic step(input string tag, input logic g0, g1, mr, mw, lto,
                      input logic [31:0] maddr,
                      input logic e0, input logic [31:0] d0,
                      input logic e1, input logic [31:0] d1);
    @(negedge clk);
    chk({tag, "_rvalid0"}, 32'(bus.p0_rvalid), 32'(rv_exp[0]));
    chk({tag, "_rvalid1"}, 32'(bus.p1_rvalid), 32'(rv_exp[1]));
    check_resp({tag, "_p0"}, bus.p0_rvalid, bus.p0_err, bus.p0_rdata, q0);
    check_resp({tag, "_p1"}, bus.p1_rvalid, bus.p1_err, bus.p1_rdata, q1);
    chk({tag, "_gnt0"}, 32'(bus.p0_gnt), 32'(g0));
    chk({tag, "_gnt1"}, 32'(bus.p1_gnt), 32'(g1));
    chk({tag, "_mem_read"}, 32'(bus.mem_read), 32'(mr));
    chk({tag, "_mem_write"}, 32'(bus.mem_write), 32'(mw));
    chk({tag, "_lock_timeout"}, 32'(bus.lock_timeout), 32'(lto));
    if (!$isunknown(maddr)) chk({tag, "_mem_addr"}, bus.mem_addr, maddr);
    rv_exp = {g1, g0};
    if (g0) q0.push_back('{err: e0, rdata: d0});
    if (g1) q1.push_back('{err: e1, rdata: d1});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    set_p0(1, 1, 0, 32'h10, 32'hDEADBEEF);
    set_p1(0, 0, 0, 32'h0, 32'h0);

    // Reset: outputs cleared and no grant even with a request pending.
    @(negedge clk);
    chk("rst_gnt0", 32'(bus.p0_gnt), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_rvalid0", 32'(bus.p0_rvalid), 32'd0);
    chk("rst_rvalid1", 32'(bus.p1_rvalid), 32'd0);
    chk("rst_err0", 32'(bus.p0_err), 32'd0);
    chk("rst_err1", 32'(bus.p1_err), 32'd0);
    chk("rst_rdata0", bus.p0_rdata, 32'd0);
    chk("rst_rdata1", bus.p1_rdata, 32'd0);
    chk("rst_lock_timeout", 32'(bus.lock_timeout), 32'd0);
    @(posedge clk);
    #1;
    set_p0(0, 0, 0, 32'h0, 32'h0);
    rst_n = 1'b1;

    // Single-port write then read-back.
    set_p0(1, 1, 0, 32'h10, 32'hDEADBEEF);
    step("p0_wr", 1, 0, 0, 1, 0, 32'h10, 0, 32'h0, 0, 32'h0);
    set_p0(1, 0, 0, 32'h10, 32'h0);
    step("p0_rd", 1, 0, 1, 0, 0, 32'h10, 0, 32'hDEADBEEF, 0, 32'h0);
    set_p0(0, 0, 0, 32'h0, 32'h0);
    set_p1(1, 1, 0, 32'h80, 32'h12345678);
    step("p1_wr", 0, 1, 0, 1, 0, 32'h80, 0, 32'h0, 0, 32'h0);

    // Both read continuously; last grant was port 1, so 0,1,0,1.
    set_p0(1, 0, 0, 32'h10, 32'h0);
    set_p1(1, 0, 0, 32'h80, 32'h0);
    for (int i = 0; i < 4; i++) begin
      logic g0;
      g0 = (i % 2 == 0);
      step("rr", g0, !g0, 1, 0, 0, g0 ? 32'h10 : 32'h80, 0, 32'hDEADBEEF, 0, 32'h12345678);
    end
    set_p0(0, 0, 0, 32'h0, 32'h0);
    set_p1(0, 0, 0, 32'h0, 32'h0);
    step("idle1", 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);

    // Make port 0 the last winner so port 1 takes the next tie with its lock.
    set_p0(1, 0, 0, 32'h10, 32'h0);
    step("p0_rd2", 1, 0, 1, 0, 0, 32'h10, 0, 32'hDEADBEEF, 0, 32'h0);

    // Port 1 lock held to timeout: 4 exclusive cycles, then port 0 wins the tie.
    set_p1(1, 0, 1, 32'h80, 32'h0);
    for (int i = 0; i < 6; i++) begin
      logic g0;
      g0 = (i == 4);
      step("lock_to", g0, !g0, 1, 0, (i == 4), g0 ? 32'h10 : 32'h80,
           0, 32'hDEADBEEF, 0, 32'h12345678);
    end
    // Cycle 5 re-locked port 1; port 0 stays blocked while port 1 owns.
    set_p1(0, 0, 0, 32'h0, 32'h0);
    step("own1_blk", 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    step("own1_rel", 1, 0, 1, 0, 0, 32'h10, 0, 32'hDEADBEEF, 0, 32'h0);
    set_p0(0, 0, 0, 32'h0, 32'h0);
    step("idle2", 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);

    // Port 0 lock dropped in cycle 2; pending port 1 granted in cycle 3.
    set_p0(1, 0, 1, 32'h10, 32'h0);
    step("lock0_c0", 1, 0, 1, 0, 0, 32'h10, 0, 32'hDEADBEEF, 0, 32'h0);
    set_p1(1, 0, 0, 32'h80, 32'h0);
    step("lock0_c1", 1, 0, 1, 0, 0, 32'h10, 0, 32'hDEADBEEF, 0, 32'h0);
    set_p0(1, 0, 0, 32'h10, 32'h0);
    step("lock0_c2", 1, 0, 1, 0, 0, 32'h10, 0, 32'hDEADBEEF, 0, 32'h0);
    set_p0(0, 0, 0, 32'h0, 32'h0);
    step("lock0_c3", 0, 1, 1, 0, 0, 32'h80, 0, 32'h0, 0, 32'h12345678);
    set_p1(0, 0, 0, 32'h0, 32'h0);
    step("idle3", 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);

    // Misaligned and out-of-range accesses: granted, no memory strobe, err response.
    set_p0(1, 0, 0, 32'h13, 32'h0);
    set_p1(1, 1, 0, 32'h4000, 32'h55555555);
    step("err_misalign", 1, 0, 0, 0, 0, 32'hx, 1, 32'h0, 0, 32'h0);
    set_p0(0, 0, 0, 32'h0, 32'h0);
    step("err_range", 0, 1, 0, 0, 0, 32'hx, 0, 32'h0, 1, 32'h0);
    set_p1(1, 1, 0, 32'h3FFC, 32'hCAFEF00D);
    step("wr_4095", 0, 1, 0, 1, 0, 32'h3FFC, 0, 32'h0, 0, 32'h0);
    set_p1(0, 0, 0, 32'h0, 32'h0);
    set_p0(1, 0, 0, 32'h3FFC, 32'h0);
    step("rd_4095", 1, 0, 1, 0, 0, 32'h3FFC, 0, 32'hCAFEF00D, 0, 32'h0);
    set_p0(0, 0, 0, 32'h0, 32'h0);
    step("idle4", 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);

    // Reset during OWN1 with a response in flight.
    set_p1(1, 0, 1, 32'h80, 32'h0);
    step("p1_lock", 0, 1, 1, 0, 0, 32'h80, 0, 32'h0, 0, 32'h12345678);
    chk("pre_rst_rvalid1", 32'(bus.p1_rvalid), 32'd1);
    set_p0(1, 0, 0, 32'h10, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid1", 32'(bus.p1_rvalid), 32'd0);
    chk("midrst_rdata1", bus.p1_rdata, 32'd0);
    chk("midrst_gnt1", 32'(bus.p1_gnt), 32'd0);
    chk("midrst_gnt0", 32'(bus.p0_gnt), 32'd0);
    chk("midrst_mem_read", 32'(bus.mem_read), 32'd0);
    q0.delete();
    q1.delete();
    rv_exp = 2'b00;
    set_p1(1, 0, 0, 32'h80, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("rst_tie", 1, 0, 1, 0, 0, 32'h10, 0, 32'hDEADBEEF, 0, 32'h12345678);
    step("rst_tie2", 0, 1, 1, 0, 0, 32'h80, 0, 32'hDEADBEEF, 0, 32'h12345678);
    set_p0(0, 0, 0, 32'h0, 32'h0);
    set_p1(0, 0, 0, 32'h0, 32'h0);
    step("idle5", 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    step("idle6", 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    chk("sb0_drained", 32'(q0.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
